// File: rtl/com_csr_pkg.sv
// Shared types and bounds for the CSR register bank.
// FSM encoding and access-latency limits live here.
package com_csr_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    WAIT = 4'b0010,
    RESP = 4'b0100,
    DONE = 4'b1000
  } csr_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = 2;

  function automatic int clamp_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/com_csr_if.sv
// CSR request/response bundle between a bus master and the bank.
// Master holds csr_valid until it sees csr_ready.
interface com_csr_if #(
  parameter int AW = 16,
  parameter int DW = 32
) ();

  logic            csr_valid;
  logic            csr_write;
  logic [AW-1:0]   csr_addr;
  logic [DW-1:0]   csr_wdata;
  logic [DW/8-1:0] csr_wstrb;
  logic            csr_ready;
  logic [DW-1:0]   csr_rdata;

  modport master (
    output csr_valid, csr_write, csr_addr,
    output csr_wdata, csr_wstrb,
    input  csr_ready, csr_rdata
  );

  modport slave (
    input  csr_valid, csr_write, csr_addr,
    input  csr_wdata, csr_wstrb,
    output csr_ready, csr_rdata
  );

endinterface

// File: rtl/com_csr_reg_cell.sv
// One CSR word with byte-strobe writes.
// RW lanes load wdata; W1C bits clear on 1 and re-set from hardware.
module com_csr_reg_cell #(
  parameter int DW  = 32,
  parameter bit W1C = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW-1:0]   hw_set_i,
  output logic [DW-1:0]   q_o
);

  localparam int SW = DW / 8;

  logic [DW-1:0] q_q;
  logic [DW-1:0] q_d;
  logic [DW-1:0] lane_m;
  logic [DW-1:0] set_m;

  always_comb begin
    lane_m = '0;
    for (int b = 0; b < SW; b++) begin
      lane_m[b*8 +: 8] = {8{wstrb_i[b]}};
    end
  end

  assign set_m = W1C ? hw_set_i : '0;

  // Hardware set is OR'd last so it wins over a same-cycle clear.
  always_comb begin
    q_d = q_q;
    if (we_i) begin
      if (W1C) q_d = q_q & ~(wdata_i & lane_m);
      else     q_d = (q_q & ~lane_m) | (wdata_i & lane_m);
    end
    q_d = q_d | set_m;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/com_csr_regbank.sv
// CSR register bank: fixed-latency single-outstanding access FSM
// over NREG word registers with RW, RO and W1C flavours.
module com_csr_regbank
  import com_csr_pkg::*;
#(
  parameter int               AW_CSR   = 16,
  parameter int               DW_CSR   = 32,
  parameter int               NREG     = 16,
  parameter int               RD_LAT   = 1,
  parameter logic [NREG-1:0]  RO_MASK  = '0,
  parameter logic [NREG-1:0]  W1C_MASK = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  com_csr_if.slave                 csr_rxif,
  output logic [NREG*DW_CSR-1:0]   reg_q,
  input  logic [NREG*DW_CSR-1:0]   hw_ro_val,
  input  logic [NREG*DW_CSR-1:0]   hw_set,
  output logic                     addr_err
);

  localparam int SW_CSR = DW_CSR / 8;
  localparam int IW     = AW_CSR - 2;
  localparam int LAT    = clamp_lat(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((LAT > 1) ? LAT - 2 : 0);

  csr_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q;
  logic [IW-1:0]     idx_q;
  logic [DW_CSR-1:0] wdata_q;
  logic [SW_CSR-1:0] wstrb_q;

  logic              cap;
  logic              oor;
  logic              in_resp;
  logic              commit;
  logic [DW_CSR-1:0] rdata;
  logic [DW_CSR-1:0] words [NREG];
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^csr_rxif.csr_addr[1:0];

  assign cap     = (state_q == IDLE) && csr_rxif.csr_valid;
  assign in_resp = (state_q == RESP);
  assign oor     = 32'(idx_q) >= 32'(NREG);
  assign commit  = in_resp && wr_q && !oor;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (csr_rxif.csr_valid) begin
          state_d = (LAT == RD_LAT_MIN) ? RESP : WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        wr_q    <= csr_rxif.csr_write;
        idx_q   <= csr_rxif.csr_addr[AW_CSR-1:2];
        wdata_q <= csr_rxif.csr_wdata;
        wstrb_q <= csr_rxif.csr_wstrb;
      end
    end
  end

  // RO cells never see a write or a set, so they hold zero;
  // the visible value comes straight from hw_ro_val.
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    logic [DW_CSR-1:0] q;
    logic              we;

    assign we = commit && (idx_q == IW'(i)) && !RO_MASK[i];

    com_csr_reg_cell #(
      .DW  (DW_CSR),
      .W1C (W1C_MASK[i] && !RO_MASK[i])
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (we),
      .wstrb_i  (wstrb_q),
      .wdata_i  (wdata_q),
      .hw_set_i (hw_set[i*DW_CSR +: DW_CSR]),
      .q_o      (q)
    );

    assign reg_q[i*DW_CSR +: DW_CSR] =
      RO_MASK[i] ? hw_ro_val[i*DW_CSR +: DW_CSR] : q;
    assign words[i] = reg_q[i*DW_CSR +: DW_CSR];
  end

  always_comb begin
    rdata = '0;
    if (in_resp && !oor) begin
      for (int i = 0; i < NREG; i++) begin
        if (idx_q == IW'(i)) rdata = words[i];
      end
    end
  end

  assign csr_rxif.csr_ready = in_resp;
  assign csr_rxif.csr_rdata = rdata;
  assign addr_err           = in_resp && oor;

endmodule

// File: tb/tb_com_csr_regbank.sv
// Directed bench for com_csr_regbank: one RD_LAT=1 and one RD_LAT=4
// instance sharing clock, reset and request fields.
module tb_com_csr_regbank;

  localparam int NR = 16;
  localparam logic [NR-1:0] RO  = 16'h0020;
  localparam logic [NR-1:0] W1C = 16'h0008;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  com_csr_if #(.AW(16), .DW(32)) if1 ();
  com_csr_if #(.AW(16), .DW(32)) if4 ();

  logic          v1, v4, t_write;
  logic [15:0]   t_addr;
  logic [31:0]   t_wdata;
  logic [3:0]    t_wstrb;
  logic [NR*32-1:0] reg_q1, reg_q4, hw_ro, hw_set1, hw_set4;
  logic          err1, err4;

  assign if1.csr_valid = v1;
  assign if1.csr_write = t_write;
  assign if1.csr_addr  = t_addr;
  assign if1.csr_wdata = t_wdata;
  assign if1.csr_wstrb = t_wstrb;
  assign if4.csr_valid = v4;
  assign if4.csr_write = t_write;
  assign if4.csr_addr  = t_addr;
  assign if4.csr_wdata = t_wdata;
  assign if4.csr_wstrb = t_wstrb;

  com_csr_regbank #(
    .AW_CSR(16), .DW_CSR(32), .NREG(NR), .RD_LAT(1),
    .RO_MASK(RO), .W1C_MASK(W1C)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .csr_rxif(if1),
    .reg_q(reg_q1), .hw_ro_val(hw_ro), .hw_set(hw_set1),
    .addr_err(err1)
  );

  com_csr_regbank #(
    .AW_CSR(16), .DW_CSR(32), .NREG(NR), .RD_LAT(4),
    .RO_MASK(RO), .W1C_MASK(W1C)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .csr_rxif(if4),
    .reg_q(reg_q4), .hw_ro_val(hw_ro), .hw_set(hw_set4),
    .addr_err(err4)
  );

  int passed = 0;
  int total  = 0;

  logic [31:0] rd;
  int          lat;
  logic        er, tl;

  function automatic logic [31:0] r1(input int i);
    return reg_q1[i*32 +: 32];
  endfunction

  function automatic logic [31:0] r4(input int i);
    return reg_q4[i*32 +: 32];
  endfunction

  // One complete access; tl reports ready/addr_err seen in the DONE cycle.
  task automatic access(input bit s4, input bit wr,
                        input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] st,
                        output logic [31:0] rdo, output int lo,
                        output logic eo, output logic to);
    @(negedge clk);
    t_write = wr; t_addr = a; t_wdata = d; t_wstrb = st;
    if (s4) v4 = 1'b1; else v1 = 1'b1;
    lo = 0; rdo = '0; eo = 1'b0;
    while (lo < 20) begin
      @(negedge clk);
      lo++;
      if (s4 ? if4.csr_ready : if1.csr_ready) begin
        rdo = s4 ? if4.csr_rdata : if1.csr_rdata;
        eo  = s4 ? err4 : err1;
        break;
      end
    end
    v1 = 1'b0; v4 = 1'b0;
    @(negedge clk);
    to = s4 ? (if4.csr_ready | err4) : (if1.csr_ready | err1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (if1.csr_ready !== 1'b0)
      $display("FAIL rst_ready: got %b want 0", if1.csr_ready); else passed++;
    total++; if (if4.csr_rdata !== 32'h0)
      $display("FAIL rst_rdata: got %h want 0", if4.csr_rdata); else passed++;
    total++; if (err1 !== 1'b0)
      $display("FAIL rst_err: got %b want 0", err1); else passed++;
    total++; if (r1(2) !== 32'h0 || r1(3) !== 32'h0)
      $display("FAIL rst_regs: got %h %h want 0", r1(2), r1(3)); else passed++;
    total++; if (r1(5) !== 32'hCAFEF00D)
      $display("FAIL rst_ro_mirror: got %h want cafef00d", r1(5)); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    access(0, 1, 16'h0008, 32'hA5A51234, 4'hF, rd, lat, er, tl);
    total++; if (lat !== 1)
      $display("FAIL wr_lat: got %0d want 1", lat); else passed++;
    total++; if (r1(2) !== 32'hA5A51234)
      $display("FAIL wr_reg2: got %h want a5a51234", r1(2)); else passed++;
    total++; if (tl !== 1'b0)
      $display("FAIL wr_ready_once: got %b want 0", tl); else passed++;
    access(0, 0, 16'h0008, 32'h0, 4'h0, rd, lat, er, tl);
    total++; if (rd !== 32'hA5A51234)
      $display("FAIL rd_reg2: got %h want a5a51234", rd); else passed++;
    access(0, 0, 16'h000A, 32'h0, 4'h0, rd, lat, er, tl);
    total++; if (rd !== 32'hA5A51234)
      $display("FAIL rd_lsb_ign: got %h want a5a51234", rd); else passed++;
  endtask

  task automatic test_strobe;
    access(0, 1, 16'h0000, 32'hFFFFFFFF, 4'h5, rd, lat, er, tl);
    total++; if (r1(0) !== 32'h00FF00FF)
      $display("FAIL strb5: got %h want 00ff00ff", r1(0)); else passed++;
    access(0, 1, 16'h0000, 32'h12345678, 4'hA, rd, lat, er, tl);
    total++; if (r1(0) !== 32'h12FF56FF)
      $display("FAIL strbA: got %h want 12ff56ff", r1(0)); else passed++;
  endtask

  task automatic test_ro;
    access(0, 1, 16'h0014, 32'h0, 4'hF, rd, lat, er, tl);
    total++; if (r1(5) !== 32'hCAFEF00D)
      $display("FAIL ro_wr_drop: got %h want cafef00d", r1(5)); else passed++;
    hw_ro[5*32 +: 32] = 32'hDEADBEEF;
    access(0, 0, 16'h0014, 32'h0, 4'h0, rd, lat, er, tl);
    total++; if (rd !== 32'hDEADBEEF)
      $display("FAIL ro_rd: got %h want deadbeef", rd); else passed++;
  endtask

  task automatic test_w1c;
    @(negedge clk);
    hw_set1[3*32 +: 32] = 32'h11;
    hw_set1[2*32 +: 32] = 32'hFFFFFFFF;
    @(negedge clk);
    hw_set1 = '0;
    total++; if (r1(2) !== 32'hA5A51234)
      $display("FAIL set_on_rw: got %h want a5a51234", r1(2)); else passed++;
    access(0, 0, 16'h000C, 32'h0, 4'h0, rd, lat, er, tl);
    total++; if (rd !== 32'h11)
      $display("FAIL w1c_set: got %h want 11", rd); else passed++;
    access(0, 1, 16'h000C, 32'h01, 4'hF, rd, lat, er, tl);
    access(0, 0, 16'h000C, 32'h0, 4'h0, rd, lat, er, tl);
    total++; if (rd !== 32'h10)
      $display("FAIL w1c_clr: got %h want 10", rd); else passed++;
    hw_set1[3*32 +: 32] = 32'h01;
    access(0, 1, 16'h000C, 32'h01, 4'hF, rd, lat, er, tl);
    hw_set1 = '0;
    @(negedge clk);
    total++; if (r1(3) !== 32'h11)
      $display("FAIL w1c_set_prio: got %h want 11", r1(3)); else passed++;
    access(0, 1, 16'h000C, 32'hFF, 4'h0, rd, lat, er, tl);
    total++; if (r1(3) !== 32'h11)
      $display("FAIL w1c_nostrb: got %h want 11", r1(3)); else passed++;
    access(0, 1, 16'h000C, 32'h11, 4'h1, rd, lat, er, tl);
    total++; if (r1(3) !== 32'h0)
      $display("FAIL w1c_clr_all: got %h want 0", r1(3)); else passed++;
  endtask

  task automatic test_oor;
    access(0, 0, 16'h0040, 32'h0, 4'h0, rd, lat, er, tl);
    total++; if (rd !== 32'h0 || er !== 1'b1 || lat !== 1)
      $display("FAIL oor_rd: got rd=%h err=%b lat=%0d want 0 1 1",
               rd, er, lat); else passed++;
    total++; if (tl !== 1'b0)
      $display("FAIL oor_err_pulse: got %b want 0", tl); else passed++;
    access(0, 1, 16'h003C, 32'h0F0F0F0F, 4'hF, rd, lat, er, tl);
    total++; if (er !== 1'b0 || r1(15) !== 32'h0F0F0F0F)
      $display("FAIL last_reg: got err=%b q=%h want 0 0f0f0f0f",
               er, r1(15)); else passed++;
    access(0, 1, 16'h0040, 32'hFFFFFFFF, 4'hF, rd, lat, er, tl);
    total++; if (er !== 1'b1)
      $display("FAIL oor_wr_err: got %b want 1", er); else passed++;
    total++; if (r1(0) !== 32'h12FF56FF || r1(15) !== 32'h0F0F0F0F)
      $display("FAIL oor_wr_drop: got %h %h want 12ff56ff 0f0f0f0f",
               r1(0), r1(15)); else passed++;
  endtask

  task automatic test_capture;
    int n;
    @(negedge clk);
    t_write = 1'b1; t_addr = 16'h0018; t_wdata = 32'h55; t_wstrb = 4'hF;
    v4 = 1'b1;
    @(negedge clk);
    t_write = 1'b0; t_addr = 16'h001C; t_wdata = 32'hFF;
    n = 1;
    while (n < 20 && !if4.csr_ready) begin
      @(negedge clk);
      n++;
    end
    v4 = 1'b0;
    total++; if (n !== 4)
      $display("FAIL cap_lat: got %0d want 4", n); else passed++;
    @(negedge clk);
    total++; if (r4(6) !== 32'h55 || r4(7) !== 32'h0)
      $display("FAIL cap_hold: got %h %h want 55 0", r4(6), r4(7));
    else passed++;
  endtask

  task automatic test_back_to_back;
    int n, k;
    int t [3];
    logic [31:0] rdv;
    t = '{0, 0, 0};
    rdv = '0;
    @(negedge clk);
    t_write = 1'b1; t_addr = 16'h0004; t_wdata = 32'h11112222; t_wstrb = 4'hF;
    v4 = 1'b1;
    n = 0; k = 0;
    while (n < 40 && k < 3) begin
      @(negedge clk);
      n++;
      if (if4.csr_ready) begin
        t[k] = n;
        if (k == 0) begin
          t_addr = 16'h0008; t_wdata = 32'h33334444;
        end else if (k == 1) begin
          t_write = 1'b0; t_addr = 16'h0004;
        end else begin
          rdv = if4.csr_rdata;
          v4 = 1'b0;
        end
        k++;
      end
    end
    v4 = 1'b0;
    @(negedge clk);
    total++; if (t[0] !== 4)
      $display("FAIL b2b_first: got %0d want 4", t[0]); else passed++;
    total++; if (t[1] !== 10 || t[2] !== 16)
      $display("FAIL b2b_spacing: got %0d %0d want 10 16", t[1], t[2]);
    else passed++;
    total++; if (r4(1) !== 32'h11112222 || r4(2) !== 32'h33334444)
      $display("FAIL b2b_regs: got %h %h want 11112222 33334444",
               r4(1), r4(2)); else passed++;
    total++; if (rdv !== 32'h11112222)
      $display("FAIL b2b_read: got %h want 11112222", rdv); else passed++;
  endtask

  task automatic test_reset_mid;
    int rdy;
    rdy = 0;
    @(negedge clk);
    t_write = 1'b1; t_addr = 16'h0020; t_wdata = 32'h0000DEAD; t_wstrb = 4'hF;
    v4 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    v4 = 1'b0;
    #1;
    total++; if (if4.csr_ready !== 1'b0 || if4.csr_rdata !== 32'h0)
      $display("FAIL rstmid_out: got %b %h want 0 0",
               if4.csr_ready, if4.csr_rdata); else passed++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (if4.csr_ready) rdy++;
    end
    total++; if (rdy !== 0)
      $display("FAIL rstmid_noready: got %0d want 0", rdy); else passed++;
    total++; if (r4(8) !== 32'h0)
      $display("FAIL rstmid_nowrite: got %h want 0", r4(8)); else passed++;
    total++; if (r1(2) !== 32'h0 || r4(1) !== 32'h0)
      $display("FAIL rstmid_clear: got %h %h want 0 0", r1(2), r4(1));
    else passed++;
    access(1, 0, 16'h0014, 32'h0, 4'h0, rd, lat, er, tl);
    total++; if (lat !== 4 || rd !== 32'hDEADBEEF)
      $display("FAIL post_rst_rd: got lat=%0d rd=%h want 4 deadbeef",
               lat, rd); else passed++;
  endtask

  initial begin
    v1 = 1'b0; v4 = 1'b0;
    t_write = 1'b0; t_addr = '0; t_wdata = '0; t_wstrb = '0;
    hw_ro = '0;
    hw_ro[5*32 +: 32] = 32'hCAFEF00D;
    hw_set1 = '0; hw_set4 = '0;
    test_reset;
    test_write_read;
    test_strobe;
    test_ro;
    test_w1c;
    test_oor;
    test_capture;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/com_csr_regbank.md
COM_CSR_REGBANK -- requirements
Module: com_csr_regbank

Interface
REQ-001 Parameter AW_CSR, default 16: CSR byte-address width.
REQ-002 Parameter DW_CSR, default 32: CSR data width; SW_CSR = DW_CSR/8.
REQ-003 Parameter NREG, default 16: number of word registers, range 1..256.
REQ-004 Parameter RD_LAT, default 1: access latency in cycles, range 1..4.
REQ-005 Parameter RO_MASK, default all-0: NREG-bit vector; bit i=1 makes register i read-only.
REQ-006 Parameter W1C_MASK, default all-0: NREG-bit vector; bit i=1 makes register i sticky/write-1-to-clear (ignored where RO_MASK=1).
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 csr_rxif  com_csr_if.slave  --  csr_valid/csr_write/csr_addr/csr_wdata/csr_wstrb in; csr_ready/csr_rdata out.
REQ-010 reg_q  output  NREG*DW_CSR  current value of every register, register i at [i*DW_CSR +: DW_CSR].
REQ-011 hw_ro_val  input  NREG*DW_CSR  value returned on reads of RO registers.
REQ-012 hw_set  input  NREG*DW_CSR  per-bit set pulses for W1C registers.
REQ-013 addr_err  output  1  one-cycle pulse on completion of an out-of-range access.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, RESP, DONE (one-hot).
REQ-015 IDLE->WAIT when csr_valid=1; WAIT counts RD_LAT-1 cycles then ->RESP (RD_LAT=1: IDLE->RESP directly).
REQ-016 csr_write, csr_addr, csr_wdata, csr_wstrb SHALL be captured on the IDLE->WAIT/RESP edge; later input changes are ignored until DONE.
REQ-017 In RESP, csr_ready=1 for exactly one cycle; csr_ready SHALL be 0 in all other states.
REQ-018 RESP->DONE unconditionally; DONE->IDLE unconditionally; csr_valid is ignored in DONE.
REQ-019 Valid-to-ready latency SHALL be exactly RD_LAT cycles from first csr_valid=1 sample in IDLE.
REQ-020 Register index = captured addr[AW_CSR-1:2]; addr[1:0] ignored; index >= NREG is out-of-range.
REQ-021 Write commits at the RESP-cycle clock edge, per byte lane where csr_wstrb bit=1.
REQ-022 RW register: byte lane takes wdata. RO register: write dropped. W1C register: bits with wdata=1 in enabled lanes cleared.
REQ-023 hw_set bit=1 on a W1C register sets that bit every cycle, with priority over a same-cycle software clear.
REQ-024 hw_set SHALL be ignored for non-W1C registers.
REQ-025 csr_rdata SHALL be valid in the RESP cycle: RW/W1C -> stored value, RO -> hw_ro_val sampled in RESP; 0 in all other states.
REQ-026 Out-of-range: write dropped, rdata=0, addr_err=1 in RESP cycle, ready still asserted (no hang).
REQ-027 reg_q of RO registers SHALL mirror hw_ro_val combinationally.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, counter 0, csr_ready=0, csr_rdata=0, addr_err=0, all RW/W1C registers 0.
REQ-029 Reset mid-access SHALL abort the access with no write committed and no ready pulse.

Structure
REQ-030 State encoding and RD_LAT bounds SHALL live in shared package com_csr_pkg.
REQ-031 One sub-module com_csr_reg_cell (one DW_CSR register with byte-strobe write, RW/W1C behaviour) SHALL be instantiated NREG times via generate.

Verification
REQ-032 RD_LAT=1, write 0xA5A5_1234 strobe 0xF to addr 0x8 -> ready 1 cycle after valid; reg_q[2]=0xA5A5_1234; read addr 0x8 returns it.
REQ-033 Write 0xFFFF_FFFF strobe 0x5 to RW reg 0 holding 0 -> reg_q[0]=0x00FF_00FF.
REQ-034 W1C reg 3: hw_set pulse 0x11 -> reads 0x11; write 0x01 -> reads 0x10; hw_set 0x01 same cycle as write 0x01 -> bit 0 stays 1.
REQ-035 NREG=16, read addr 0x40 -> rdata 0, addr_err pulse 1 cycle, ready asserted; write to 0x40 changes no reg_q.
REQ-036 RD_LAT=4, back-to-back APB-paced accesses -> ready exactly 4 cycles after each valid, one DONE gap between.
REQ-037 Assert rst_n=0 in WAIT of a write -> no ready pulse, target register remains 0 after reset release.
